cochlea_chan_ctrl: RTL

Digital control and readout stage for one switched-cap filter channel. It sits directly around the analog filter macro.
- Drives the macro's clock inputs cclk, div2 and lo, and its feedback input fb1.
- Synchronizes the macro's comparator output high_buf and its phase clock phi1b_dig into the digital core clock domain.
- Closes the 1-bit feedback loop.
- Encodes comparator decision changes as timestamped polarity events in a small ready/valid FIFO for the downstream event aggregator.

---
 rtl/cochlea_pkg.sv | 14 +
 rtl/cochlea_chan_ctrl_if.sv | 16 +
 rtl/cochlea_ev_fifo.sv | 66 ++++++
 rtl/cochlea_chan_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cochlea_pkg.sv
// Shared types and default widths for the cochlea filter-channel control block.
package cochlea_pkg;

  localparam int DEF_DIV_W   = 8;
  localparam int DEF_LO_W    = 4;
  localparam int DEF_TS_W    = 16;
  localparam int SYNC_STAGES = 2;

  typedef struct packed {
    logic                 pol;
    logic [DEF_TS_W-1:0]  ts;
  } cochlea_ev_t;

endpackage

// File: rtl/cochlea_chan_ctrl_if.sv
// Ready/valid event port between the channel controller and the event aggregator.
interface cochlea_chan_ctrl_if
  import cochlea_pkg::*;
#(
  parameter int TS_W = DEF_TS_W
);

  logic            ev_valid;
  logic            ev_ready;
  logic            ev_pol;
  logic [TS_W-1:0] ev_ts;

  modport master (output ev_valid, ev_pol, ev_ts, input ev_ready);
  modport slave  (input ev_valid, ev_pol, ev_ts, output ev_ready);

endinterface

// File: rtl/cochlea_ev_fifo.sv
// First-word-fall-through event FIFO; a push onto a full FIFO without a pop is dropped and flagged.
module cochlea_ev_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push_i & (~full | do_pop);
  assign drop_o  = push_i & full & ~do_pop;

  // Head is zeroed while empty so the outputs read 0 without resetting storage.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cochlea_chan_ctrl.sv
// Clock generation, input synchronization, 1-bit feedback decision and event encoding
// for one switched-cap filter channel.
module cochlea_chan_ctrl
  import cochlea_pkg::*;
#(
  parameter int DIV_W      = DEF_DIV_W,
  parameter int LO_W       = DEF_LO_W,
  parameter int TS_W       = DEF_TS_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [DIV_W-1:0]   div_cfg,
  input  logic [LO_W-1:0]    lo_cfg,
  output logic               cclk,
  output logic               div2,
  output logic               lo,
  output logic               fb1,
  input  logic               high_buf,
  input  logic               phi1b_dig,
  cochlea_chan_ctrl_if.master ev,
  output logic               ovf,
  input  logic               ovf_clr
);

  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic [LO_W-1:0]        lo_cnt_q, lo_cnt_d;
  logic                   cclk_q, cclk_d;
  logic                   div2_q, div2_d;
  logic                   lo_q, lo_d;
  logic                   cclk_rise;

  logic [SYNC_STAGES-1:0] phi_sync_q;
  logic [SYNC_STAGES-1:0] high_sync_q;
  logic                   phi_s3_q;
  logic                   phi_s2, high_s2, det, decide;

  logic                   fb1_q, fb1_d;
  logic                   prev_q, prev_d;
  logic [TS_W-1:0]        ts_q;
  logic                   ovf_q, ovf_d;

  logic                   ev_push, ev_pop;
  logic                   fifo_empty, fifo_drop;
  logic [TS_W:0]          fifo_rdata;

  // Divider: cclk half-period is div_cfg+1 clk cycles; div2 and lo advance on cclk rising.
  always_comb begin
    div_cnt_d = div_cnt_q;
    cclk_d    = cclk_q;
    div2_d    = div2_q;
    lo_cnt_d  = lo_cnt_q;
    lo_d      = lo_q;
    cclk_rise = 1'b0;
    if (!en) begin
      div_cnt_d = '0;
      cclk_d    = 1'b0;
      div2_d    = 1'b0;
      lo_cnt_d  = '0;
      lo_d      = 1'b0;
    end else begin
      // >= so that lowering div_cfg mid-count wraps immediately instead of running to overflow.
      if (div_cnt_q >= div_cfg) begin
        div_cnt_d = '0;
        cclk_d    = ~cclk_q;
        cclk_rise = ~cclk_q;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
      if (cclk_rise) begin
        div2_d = ~div2_q;
        if (lo_cnt_q >= lo_cfg) begin
          lo_cnt_d = '0;
          lo_d     = ~lo_q;
        end else begin
          lo_cnt_d = lo_cnt_q + 1'b1;
        end
      end
    end
  end

  assign phi_s2  = phi_sync_q[SYNC_STAGES-1];
  assign high_s2 = high_sync_q[SYNC_STAGES-1];
  assign det     = phi_s2 & ~phi_s3_q;
  assign decide  = en & det;
  assign ev_push = decide & (high_s2 != prev_q);
  assign ev_pop  = ~fifo_empty & ev.ev_ready;

  always_comb begin
    fb1_d  = fb1_q;
    prev_d = prev_q;
    ovf_d  = ovf_q;
    if (decide) begin
      fb1_d  = high_s2;
      prev_d = high_s2;
    end
    // An overflow in the same cycle as a clear must stay visible.
    if (fifo_drop)    ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      div_cnt_q   <= '0;
      cclk_q      <= 1'b0;
      div2_q      <= 1'b0;
      lo_cnt_q    <= '0;
      lo_q        <= 1'b0;
      phi_sync_q  <= '0;
      high_sync_q <= '0;
      phi_s3_q    <= 1'b0;
      fb1_q       <= 1'b0;
      prev_q      <= 1'b0;
      ts_q        <= '0;
      ovf_q       <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      cclk_q      <= cclk_d;
      div2_q      <= div2_d;
      lo_cnt_q    <= lo_cnt_d;
      lo_q        <= lo_d;
      phi_sync_q  <= {phi_sync_q[SYNC_STAGES-2:0], phi1b_dig};
      high_sync_q <= {high_sync_q[SYNC_STAGES-2:0], high_buf};
      phi_s3_q    <= phi_s2;
      fb1_q       <= fb1_d;
      prev_q      <= prev_d;
      ts_q        <= ts_q + 1'b1;
      ovf_q       <= ovf_d;
    end
  end

  cochlea_ev_fifo #(
    .WIDTH (TS_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstb    (rstb),
    .push_i  (ev_push),
    .wdata_i ({high_s2, ts_q}),
    .pop_i   (ev_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  assign cclk        = cclk_q;
  assign div2        = div2_q;
  assign lo          = lo_q;
  assign fb1         = fb1_q;
  assign ovf         = ovf_q;
  assign ev.ev_valid = ~fifo_empty;
  assign ev.ev_pol   = fifo_rdata[TS_W];
  assign ev.ev_ts    = fifo_rdata[TS_W-1:0];

endmodule
